// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, keeps at most one icache read in flight and buffers one instruction for decode.
// Optional performance counters are built only when IFU_PERF_CNT_EN is defined.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ic_valid,
  output logic [5:0]  ic_index,
  output logic [22:0] ic_tag,
  output logic [2:0]  ic_offset,
  input  logic        ic_addr_ok,
  input  logic        ic_data_ok,
  input  logic [31:0] ic_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        transfer;
  logic        accept;

  assign transfer   = inst_valid_q && inst_ready;
  assign ic_valid   = !rst && (state_q == S_REQ) && (!inst_valid_q || inst_ready);
  assign accept     = ic_valid && ic_addr_ok;
  assign ic_tag     = pc_q[31:9];
  assign ic_index   = pc_q[8:3];
  assign ic_offset  = pc_q[2:0];
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q && !transfer;

    case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (ic_data_ok) begin
          inst_d       = ic_rdata;
          inst_pc_d    = req_pc_q;
          inst_valid_d = 1'b1;
          pc_d         = req_pc_q + PC_STEP;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        if (ic_data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // A redirect wins: any response landing this cycle is stale, and an in-flight request must be dropped.
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      if (state_q == S_REQ) state_d = accept ? S_DROP : S_REQ;
      else                  state_d = ic_data_ok ? S_REQ : S_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = transfer ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    stall_cnt_d = (state_q != S_REQ) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a small icache responder, request/delivery queues and directed scenarios.
// Counter checks are compiled in only when IFU_PERF_CNT_EN is defined, matching the DUT build.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } deliv_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_valid;
  logic [5:0]  ic_index;
  logic [22:0] ic_tag;
  logic [2:0]  ic_offset;
  logic        ic_addr_ok;
  logic        ic_data_ok;
  logic [31:0] ic_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int compared   = 0;
  int mismatched = 0;
  int acceptCnt  = 0;
  int latency    = 2;
  int base       = 0;

  deliv_t      expQ[$];
  logic [31:0] reqQ[$];
  logic [31:0] ovrQ[$];

  logic [31:0] expReq;
  deliv_t      expDel;
  logic        holdPrev = 1'b0;
  logic [31:0] prevInst = 32'h0;
  logic [31:0] prevPc   = 32'h0;
  logic        pending  = 1'b0;
  int          pendCnt  = 0;
  logic [31:0] pendAddr = 32'h0;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .ic_valid       (ic_valid),
    .ic_index       (ic_index),
    .ic_tag         (ic_tag),
    .ic_offset      (ic_offset),
    .ic_addr_ok     (ic_addr_ok),
    .ic_data_ok     (ic_data_ok),
    .ic_rdata       (ic_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagFail(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got 0x%08h with nothing expected at %0t", name, act, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic aok,
                               input logic rv, input logic [31:0] rpc);
    rst            = r;
    inst_ready     = rdy;
    ic_addr_ok     = aok;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles; leaves the caller at the start of the first cycle it may release reset in.
  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("reset ic_valid", 32'(ic_valid), 32'h0);
    checkOutput("reset inst_valid", 32'(inst_valid), 32'h0);
    checkOutput("reset inst", inst, 32'h0);
    checkOutput("reset inst_pc", inst_pc, 32'h0);
    checkOutput("reset ic_addr", {ic_tag, ic_index, ic_offset}, 32'h8000_0000);
    checkOutput("reset perf_fetch", perf_fetch_cnt, 32'h0);
    checkOutput("reset perf_stall", perf_stall_cnt, 32'h0);
    nextCycle();
  endtask

  task automatic waitAccepts(input int target);
    int n = 0;
    while (acceptCnt < target && n < 60) begin
      nextCycle();
      n++;
    end
    if (acceptCnt < target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept timeout: got %0d accepts, required %0d", acceptCnt, target);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 80) begin
      nextCycle();
      n++;
    end
    checkOutput("delivery drain", 32'(expQ.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic checkPerf(input logic [31:0] fetches, input logic [31:0] stalls);
`ifdef IFU_PERF_CNT_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, fetches);
    checkOutput("perf_stall_cnt", perf_stall_cnt, stalls);
`else
    checkOutput("perf_fetch_cnt tied", perf_fetch_cnt, 32'h0);
    checkOutput("perf_stall_cnt tied", perf_stall_cnt, 32'h0 & stalls & fetches);
`endif
  endtask

  // icache responder: accepts one request, answers 'latency' cycles later with ~addr or a queued override word.
  initial begin
    ic_data_ok = 1'b0;
    ic_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) checkOutput("no request while outstanding", 32'(ic_valid), 32'h0);
        if (ic_valid && ic_addr_ok) begin
          pending  = 1'b1;
          pendCnt  = latency;
          pendAddr = {ic_tag, ic_index, ic_offset};
        end
      end
      @(posedge clk);
      #1;
      ic_data_ok = 1'b0;
      if (pending) begin
        pendCnt--;
        if (pendCnt <= 0) begin
          ic_data_ok = 1'b1;
          ic_rdata   = (ovrQ.size() != 0) ? ovrQ.pop_front() : ~pendAddr;
          pending    = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expected requests on accept and expected instructions on decode transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ic_valid && ic_addr_ok) begin
        acceptCnt++;
        if (reqQ.size() == 0) begin
          flagFail("unexpected request", {ic_tag, ic_index, ic_offset});
        end else begin
          expReq = reqQ.pop_front();
          checkOutput("req ic_tag", 32'(ic_tag), 32'(expReq[31:9]));
          checkOutput("req ic_index", 32'(ic_index), 32'(expReq[8:3]));
          checkOutput("req ic_offset", 32'(ic_offset), 32'(expReq[2:0]));
        end
      end
      if (!rst && holdPrev && inst_valid) begin
        checkOutput("hold inst stable", inst, prevInst);
        checkOutput("hold inst_pc stable", inst_pc, prevPc);
      end
      if (!rst && inst_valid && inst_ready) begin
        if (expQ.size() == 0) begin
          flagFail("unexpected delivery", inst_pc);
        end else begin
          expDel = expQ.pop_front();
          checkOutput("deliver inst", inst, expDel.word);
          checkOutput("deliver inst_pc", inst_pc, expDel.pc);
        end
      end
      holdPrev = !rst && inst_valid && !inst_ready && !redirect_valid;
      prevInst = inst;
      prevPc   = inst_pc;
    end
  end

  initial begin
    int n;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Hits back to back with decode always ready.
    $display("[TB] scenario: sequential hits");
    doReset();
    latency = 2;
    reqQ.push_back(32'h8000_0000);
    reqQ.push_back(32'h8000_0004);
    reqQ.push_back(32'h8000_0008);
    expQ.push_back('{word: 32'h7FFF_FFFF, pc: 32'h8000_0000});
    expQ.push_back('{word: 32'h7FFF_FFFB, pc: 32'h8000_0004});
    expQ.push_back('{word: 32'h7FFF_FFF7, pc: 32'h8000_0008});
    base = acceptCnt;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitAccepts(base + 3);
    ic_addr_ok = 1'b0;
    waitDrain();
    checkPerf(32'd3, 32'd6);

    // Miss with a five-cycle response.
    $display("[TB] scenario: miss");
    doReset();
    latency = 5;
    ovrQ.push_back(32'h0000_0413);
    reqQ.push_back(32'h8000_0000);
    expQ.push_back('{word: 32'h0000_0413, pc: 32'h8000_0000});
    base = acceptCnt;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitAccepts(base + 1);
    ic_addr_ok = 1'b0;
    waitDrain();
    checkPerf(32'd1, 32'd5);

    // Decode back-pressure for four cycles after the first delivery.
    $display("[TB] scenario: decode stall");
    doReset();
    latency = 2;
    reqQ.push_back(32'h8000_0000);
    reqQ.push_back(32'h8000_0004);
    expQ.push_back('{word: 32'h7FFF_FFFF, pc: 32'h8000_0000});
    expQ.push_back('{word: 32'h7FFF_FFFB, pc: 32'h8000_0004});
    base = acceptCnt;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall inst_valid", 32'(inst_valid), 32'h1);
      checkOutput("stall ic_valid", 32'(ic_valid), 32'h0);
      checkOutput("stall inst", inst, 32'h7FFF_FFFF);
      checkOutput("stall inst_pc", inst_pc, 32'h8000_0000);
      if (i < 3) @(negedge clk);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitAccepts(base + 2);
    ic_addr_ok = 1'b0;
    waitDrain();
    checkPerf(32'd2, 32'd4);

    // Redirect while waiting on a miss; the stale 0xDEADBEEF must never reach decode.
    $display("[TB] scenario: redirect in WAIT");
    doReset();
    latency = 5;
    ovrQ.push_back(32'hDEAD_BEEF);
    reqQ.push_back(32'h8000_0000);
    reqQ.push_back(32'h8000_1000);
    expQ.push_back('{word: 32'h7FFF_EFFF, pc: 32'h8000_1000});
    base = acceptCnt;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitAccepts(base + 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_1000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("drop ic_valid", 32'(ic_valid), 32'h0);
    checkOutput("drop inst_valid", 32'(inst_valid), 32'h0);
    waitAccepts(base + 2);
    ic_addr_ok = 1'b0;
    waitDrain();
    checkPerf(32'd1, 32'd10);

    // Redirect on the accept cycle, then a second redirect while dropping.
    $display("[TB] scenario: redirect on accept and in DROP");
    doReset();
    latency = 4;
    reqQ.push_back(32'h8000_0000);
    reqQ.push_back(32'h8000_2000);
    expQ.push_back('{word: 32'h7FFF_DFFF, pc: 32'h8000_2000});
    base = acceptCnt;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_1000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_2000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitAccepts(base + 2);
    ic_addr_ok = 1'b0;
    waitDrain();
    checkPerf(32'd1, 32'd8);

    // Reset while a request is outstanding.
    $display("[TB] scenario: reset in WAIT");
    doReset();
    latency = 5;
    reqQ.push_back(32'h8000_0000);
    reqQ.push_back(32'h8000_0000);
    expQ.push_back('{word: 32'h7FFF_FFFF, pc: 32'h8000_0000});
    base = acceptCnt;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    waitAccepts(base + 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("mid-reset ic_valid", 32'(ic_valid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("post-reset inst_valid", 32'(inst_valid), 32'h0);
    nextCycle();
    waitAccepts(base + 2);
    ic_addr_ok = 1'b0;
    waitDrain();
    checkPerf(32'd1, 32'd5);

    checkOutput("leftover requests", 32'(reqQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
